// File: rtl/dcache_bus_ctrl_pkg.sv
// Shared types and encodings for the snooping D-cache bus controller and its
// response queue.
package dcache_bus_ctrl_pkg;

  localparam int DCACHE_TAG_W = 55;
  localparam int DCACHE_IDX_W = 6;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    GET_S = 2'd1,
    GET_M = 2'd2,
    PUT_M = 2'd3
  } message_t;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef logic [2:0] bus_state_t;
  localparam bus_state_t ST_IDLE        = 3'd0;
  localparam bus_state_t ST_GRANT       = 3'd1;
  localparam bus_state_t ST_MEM_RD_REQ  = 3'd2;
  localparam bus_state_t ST_MEM_RD_WAIT = 3'd3;
  localparam bus_state_t ST_MEM_WR_REQ  = 3'd4;

  typedef struct packed {
    logic        id;
    logic [63:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/dcache_bus_ctrl_rspq.sv
// rspq_fifo: small circular response queue holding {core id, 64-bit data}
// entries in arrival order.
module rspq_fifo
  import dcache_bus_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  rsp_entry_t       din,
  output rsp_entry_t       dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  rsp_entry_t       mem_q [DEPTH];
  rsp_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately left unreset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dcache_bus_ctrl.sv
// Snooping bus controller for two D-cache controllers: round-robin grant,
// same-cycle snoop data, memory load/store fallback, response queue.
module dcache_bus_ctrl
  import dcache_bus_ctrl_pkg::*;
#(
  parameter int NCPU       = 2,
  parameter int RSPQ_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NCPU-1:0]                      Dctrl2bus_req_en_i,
  input  logic [NCPU-1:0][DCACHE_TAG_W-1:0]    Dctrl2bus_req_tag_i,
  input  logic [NCPU-1:0][DCACHE_IDX_W-1:0]    Dctrl2bus_req_idx_i,
  input  logic [NCPU-1:0][63:0]                Dctrl2bus_req_data_i,
  input  message_t [NCPU-1:0]                  Dctrl2bus_req_message_i,
  output logic                                 bus2Dctrl_req_ack_o,
  output logic                                 bus2Dctrl_req_id_o,
  output logic [DCACHE_TAG_W-1:0]              bus2Dctrl_req_tag_o,
  output logic [DCACHE_IDX_W-1:0]              bus2Dctrl_req_idx_o,
  output message_t                             bus2Dctrl_req_message_o,
  input  logic [NCPU-1:0]                      Dctrl2bus_rsp_vld_i,
  input  logic [NCPU-1:0][63:0]                Dctrl2bus_rsp_data_i,
  output logic                                 bus2Dctrl_rsp_vld_o,
  output logic                                 bus2Dctrl_rsp_id_o,
  output logic [63:0]                          bus2Dctrl_rsp_data_o,
  input  logic [NCPU-1:0]                      Dctrl2bus_rsp_ack_i,
  output logic [1:0]                           bus2mem_command_o,
  output logic [63:0]                          bus2mem_addr_o,
  output logic [63:0]                          bus2mem_data_o,
  input  logic [3:0]                           mem2bus_response_i,
  input  logic [3:0]                           mem2bus_tag_i,
  input  logic [63:0]                          mem2bus_data_i
);

  localparam int CNT_W = $clog2(RSPQ_DEPTH + 1);

  bus_state_t              state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    lat_id_q, lat_id_d;
  logic [DCACHE_TAG_W-1:0] lat_tag_q, lat_tag_d;
  logic [DCACHE_IDX_W-1:0] lat_idx_q, lat_idx_d;
  logic [63:0]             lat_data_q, lat_data_d;
  message_t                lat_msg_q, lat_msg_d;
  logic [3:0]              mem_tag_q, mem_tag_d;

  logic                    win_id;
  logic                    push_req;
  rsp_entry_t              push_entry;
  rsp_entry_t              head;
  logic [CNT_W-1:0]        rspq_count;
  logic                    rspq_full, rspq_empty;
  logic                    rspq_push, rspq_pop;
  logic [63:0]             lat_addr;

  assign lat_addr = {lat_tag_q, lat_idx_q, 3'b000};

  // Both requesting: the core that did not win last time goes first.
  always_comb begin
    if (Dctrl2bus_req_en_i[0] && Dctrl2bus_req_en_i[1]) win_id = ~last_grant_q;
    else                                                 win_id = Dctrl2bus_req_en_i[1];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_id_d     = lat_id_q;
    lat_tag_d    = lat_tag_q;
    lat_idx_d    = lat_idx_q;
    lat_data_d   = lat_data_q;
    lat_msg_d    = lat_msg_q;
    mem_tag_d    = mem_tag_q;
    push_req     = 1'b0;
    push_entry   = '0;
    case (state_q)
      ST_IDLE: begin
        if ((|Dctrl2bus_req_en_i) && (rspq_count < CNT_W'(RSPQ_DEPTH))) begin
          lat_id_d     = win_id;
          lat_tag_d    = Dctrl2bus_req_tag_i[win_id];
          lat_idx_d    = Dctrl2bus_req_idx_i[win_id];
          lat_data_d   = Dctrl2bus_req_data_i[win_id];
          lat_msg_d    = Dctrl2bus_req_message_i[win_id];
          last_grant_d = win_id;
          state_d      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        case (lat_msg_q)
          GET_S: begin
            // Only the other core's snoop can supply the line.
            if (Dctrl2bus_rsp_vld_i[~lat_id_q]) begin
              push_req   = 1'b1;
              push_entry = '{id: lat_id_q, data: Dctrl2bus_rsp_data_i[~lat_id_q]};
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_MEM_RD_REQ;
            end
          end
          PUT_M:   state_d = ST_MEM_WR_REQ;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_MEM_RD_REQ: begin
        if (mem2bus_response_i != 4'd0) begin
          mem_tag_d = mem2bus_response_i;
          state_d   = ST_MEM_RD_WAIT;
        end
      end
      ST_MEM_RD_WAIT: begin
        if ((mem_tag_q != 4'd0) && (mem2bus_tag_i == mem_tag_q)) begin
          push_req   = 1'b1;
          push_entry = '{id: lat_id_q, data: mem2bus_data_i};
          mem_tag_d  = 4'd0;
          state_d    = ST_IDLE;
        end
      end
      ST_MEM_WR_REQ: begin
        if (mem2bus_response_i != 4'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus2Dctrl_req_ack_o     = 1'b0;
    bus2Dctrl_req_id_o      = 1'b0;
    bus2Dctrl_req_tag_o     = '0;
    bus2Dctrl_req_idx_o     = '0;
    bus2Dctrl_req_message_o = NONE;
    bus2mem_command_o       = BUS_NONE;
    bus2mem_addr_o          = '0;
    bus2mem_data_o          = '0;
    case (state_q)
      ST_GRANT: begin
        bus2Dctrl_req_ack_o     = 1'b1;
        bus2Dctrl_req_id_o      = lat_id_q;
        bus2Dctrl_req_tag_o     = lat_tag_q;
        bus2Dctrl_req_idx_o     = lat_idx_q;
        bus2Dctrl_req_message_o = lat_msg_q;
      end
      ST_MEM_RD_REQ: begin
        bus2mem_command_o = BUS_LOAD;
        bus2mem_addr_o    = lat_addr;
      end
      ST_MEM_WR_REQ: begin
        bus2mem_command_o = BUS_STORE;
        bus2mem_addr_o    = lat_addr;
        bus2mem_data_o    = lat_data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      lat_id_q     <= 1'b0;
      lat_tag_q    <= '0;
      lat_idx_q    <= '0;
      lat_data_q   <= '0;
      lat_msg_q    <= NONE;
      mem_tag_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_id_q     <= lat_id_d;
      lat_tag_q    <= lat_tag_d;
      lat_idx_q    <= lat_idx_d;
      lat_data_q   <= lat_data_d;
      lat_msg_q    <= lat_msg_d;
      mem_tag_q    <= mem_tag_d;
    end
  end

  assign rspq_push = push_req & ~rspq_full;
  assign rspq_pop  = ~rspq_empty & Dctrl2bus_rsp_ack_i[head.id];

  rspq_fifo #(.DEPTH(RSPQ_DEPTH)) u_rspq (
    .clk   (clk),
    .rst   (rst),
    .push  (rspq_push),
    .pop   (rspq_pop),
    .din   (push_entry),
    .dout  (head),
    .count (rspq_count),
    .full  (rspq_full),
    .empty (rspq_empty)
  );

  // Head fields are masked while empty so stale storage never shows.
  assign bus2Dctrl_rsp_vld_o  = ~rspq_empty;
  assign bus2Dctrl_rsp_id_o   = head.id & ~rspq_empty;
  assign bus2Dctrl_rsp_data_o = rspq_empty ? 64'd0 : head.data;

endmodule

// File: tb/tb_dcache_bus_ctrl.sv
// Directed self-checking bench for dcache_bus_ctrl: snoop hit, memory load,
// round-robin, store, queue-full back-pressure and reset abandonment.
module tb_dcache_bus_ctrl;
  import dcache_bus_ctrl_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst;
  logic [1:0]                        req_en;
  logic [1:0][DCACHE_TAG_W-1:0]      req_tag;
  logic [1:0][DCACHE_IDX_W-1:0]      req_idx;
  logic [1:0][63:0]                  req_data;
  message_t [1:0]                    req_msg;
  logic                              ack, gid;
  logic [DCACHE_TAG_W-1:0]           gtag;
  logic [DCACHE_IDX_W-1:0]           gidx;
  message_t                          gmsg;
  logic [1:0]                        snp_vld;
  logic [1:0][63:0]                  snp_data;
  logic                              rvld, rid;
  logic [63:0]                       rdata;
  logic [1:0]                        rsp_ack;
  logic [1:0]                        cmd;
  logic [63:0]                       maddr, mdata;
  logic [3:0]                        mem_resp, mem_tag;
  logic [63:0]                       mem_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_bus_ctrl #(.NCPU(2), .RSPQ_DEPTH(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .Dctrl2bus_req_en_i      (req_en),
    .Dctrl2bus_req_tag_i     (req_tag),
    .Dctrl2bus_req_idx_i     (req_idx),
    .Dctrl2bus_req_data_i    (req_data),
    .Dctrl2bus_req_message_i (req_msg),
    .bus2Dctrl_req_ack_o     (ack),
    .bus2Dctrl_req_id_o      (gid),
    .bus2Dctrl_req_tag_o     (gtag),
    .bus2Dctrl_req_idx_o     (gidx),
    .bus2Dctrl_req_message_o (gmsg),
    .Dctrl2bus_rsp_vld_i     (snp_vld),
    .Dctrl2bus_rsp_data_i    (snp_data),
    .bus2Dctrl_rsp_vld_o     (rvld),
    .bus2Dctrl_rsp_id_o      (rid),
    .bus2Dctrl_rsp_data_o    (rdata),
    .Dctrl2bus_rsp_ack_i     (rsp_ack),
    .bus2mem_command_o       (cmd),
    .bus2mem_addr_o          (maddr),
    .bus2mem_data_o          (mdata),
    .mem2bus_response_i      (mem_resp),
    .mem2bus_tag_i           (mem_tag),
    .mem2bus_data_i          (mem_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    req_en   = '0;
    req_tag  = '0;
    req_idx  = '0;
    req_data = '0;
    req_msg[0] = NONE;
    req_msg[1] = NONE;
    snp_vld  = '0;
    snp_data = '0;
    rsp_ack  = '0;
    mem_resp = '0;
    mem_tag  = '0;
    mem_data = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_ack", ack, 0);
    check("rst_msg", gmsg, NONE);
    check("rst_cmd", cmd, BUS_NONE);
    check("rst_rvld", rvld, 0);
    check("rst_addr", maddr, 0);

    // Core0 GET_S, core1 snoop hit
    req_en[0] = 1'b1; req_tag[0] = 55'd5; req_idx[0] = 6'd2; req_msg[0] = GET_S;
    tick();
    req_en[0] = 1'b0;
    check("hit_ack", ack, 1);
    check("hit_id", gid, 0);
    check("hit_tag", gtag, 5);
    check("hit_idx", gidx, 2);
    check("hit_msg", gmsg, GET_S);
    check("hit_cmd", cmd, BUS_NONE);
    snp_vld[1] = 1'b1; snp_data[1] = 64'hAA;
    tick();
    snp_vld[1] = 1'b0;
    check("hit_ack_drop", ack, 0);
    check("hit_rvld", rvld, 1);
    check("hit_rid", rid, 0);
    check("hit_rdata", rdata, 64'hAA);
    check("hit_cmd2", cmd, BUS_NONE);
    rsp_ack[0] = 1'b1;
    tick();
    rsp_ack[0] = 1'b0;
    check("hit_pop", rvld, 0);

    // Core1 GET_S miss; own snoop valid must be ignored
    req_en[1] = 1'b1; req_tag[1] = 55'd7; req_idx[1] = 6'd1; req_msg[1] = GET_S;
    tick();
    req_en[1] = 1'b0;
    check("miss_ack", ack, 1);
    check("miss_id", gid, 1);
    snp_vld[1] = 1'b1; snp_data[1] = 64'h55;
    tick();
    snp_vld[1] = 1'b0;
    check("miss_rvld0", rvld, 0);
    check("miss_load1", cmd, BUS_LOAD);
    check("miss_addr", maddr, {55'd7, 6'd1, 3'b000});
    tick();
    check("miss_load2", cmd, BUS_LOAD);
    tick();
    check("miss_load3", cmd, BUS_LOAD);
    mem_resp = 4'd3;
    tick();
    mem_resp = 4'd0;
    check("miss_wait_cmd", cmd, BUS_NONE);
    mem_tag = 4'd2; mem_data = 64'hBAD;
    tick();
    check("miss_wrong_tag", rvld, 0);
    mem_tag = 4'd3; mem_data = 64'h1234;
    tick();
    mem_tag = 4'd0; mem_data = 64'd0;
    check("miss_rvld", rvld, 1);
    check("miss_rid", rid, 1);
    check("miss_rdata", rdata, 64'h1234);
    rsp_ack[1] = 1'b1;
    tick();
    rsp_ack[1] = 1'b0;
    check("miss_pop", rvld, 0);

    // Both cores GET_M continuously: grants 0,1,0,1
    req_en = 2'b11; req_msg[0] = GET_M; req_msg[1] = GET_M;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_ack", ack, 1);
      check("rr_id", gid, k % 2);
      tick();
      check("rr_gap", ack, 0);
    end
    req_en = 2'b00;
    check("rr_no_rsp", rvld, 0);

    // Core0 PUT_M
    req_en[0] = 1'b1; req_tag[0] = 55'h1F; req_idx[0] = 6'd3; req_data[0] = 64'hDEAD; req_msg[0] = PUT_M;
    tick();
    req_en[0] = 1'b0;
    check("put_ack", ack, 1);
    check("put_msg", gmsg, PUT_M);
    tick();
    check("put_cmd1", cmd, BUS_STORE);
    check("put_addr", maddr, {55'h1F, 6'd3, 3'b000});
    check("put_data", mdata, 64'hDEAD);
    tick();
    check("put_cmd2", cmd, BUS_STORE);
    mem_resp = 4'd5;
    tick();
    mem_resp = 4'd0;
    check("put_done_cmd", cmd, BUS_NONE);
    check("put_done_data", mdata, 0);

    // Fill the response queue with four snoop hits, no pops
    req_msg[0] = GET_S;
    for (int i = 0; i < 4; i++) begin
      req_en[0] = 1'b1;
      tick();
      req_en[0] = 1'b0;
      check("fill_ack", ack, 1);
      snp_vld[1] = 1'b1; snp_data[1] = 64'h10 + 64'(i);
      tick();
      snp_vld[1] = 1'b0;
    end
    req_en[0] = 1'b1;
    tick();
    check("full_no_grant", ack, 0);
    rsp_ack[1] = 1'b1;
    tick();
    rsp_ack[1] = 1'b0;
    check("full_wrong_ack", ack, 0);
    check("full_head_kept", rdata, 64'h10);
    rsp_ack[0] = 1'b1;
    tick();
    rsp_ack[0] = 1'b0;
    check("full_pop_no_grant", ack, 0);
    check("full_head_next", rdata, 64'h11);
    tick();
    check("full_grant", ack, 1);
    check("full_grant_id", gid, 0);
    req_en[0] = 1'b0;
    snp_vld[1] = 1'b1; snp_data[1] = 64'h14;
    tick();
    snp_vld[1] = 1'b0;
    check("full_refill", rvld, 1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", rdata, 64'h10 + 64'(i));
      rsp_ack[0] = 1'b1;
      tick();
      rsp_ack[0] = 1'b0;
    end
    check("drain_empty", rvld, 0);

    // Reset during MEM_RD_WAIT; late completion must be dropped
    req_en[1] = 1'b1; req_tag[1] = 55'd9; req_idx[1] = 6'd4; req_msg[1] = GET_S;
    tick();
    req_en[1] = 1'b0;
    tick();
    check("rw_load", cmd, BUS_LOAD);
    mem_resp = 4'd6;
    tick();
    mem_resp = 4'd0;
    check("rw_wait", cmd, BUS_NONE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_tag = 4'd6; mem_data = 64'hBEEF;
    tick();
    mem_tag = 4'd0; mem_data = 64'd0;
    check("rw_rvld", rvld, 0);
    check("rw_ack", ack, 0);
    check("rw_cmd", cmd, BUS_NONE);
    check("rw_rdata", rdata, 0);
    tick();
    check("rw_rvld2", rvld, 0);
    req_en = 2'b11; req_msg[0] = GET_M; req_msg[1] = GET_M;
    tick();
    req_en = 2'b00;
    check("rw_first_grant", gid, 0);
    check("rw_first_ack", ack, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
